// File: rtl/seven_seg_scan_dec.sv
// seven_seg_scan_dec
//
// Receive-side decoder for a time-multiplexed, active-low 7-segment display
// bus. The shared segment lines and per-digit anode enables are sampled, each
// digit's glyph is captured once it has been stable long enough, and the
// glyph is turned back into the 4-bit hex value it represents.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits / anode lines (1..8)
//   STABLE_CYCLES  consecutive identical samples needed before a capture (>=2)
//   TIMEOUT_CYCLES cycles without a fresh capture before a digit's valid drops
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   seg_n        segment lines, active-low, bit0=a ... bit6=g
//   an_n         anode enables, active-low, one-hot when driven
//   digits       decoded hex, digit k in bits [4k+3:4k]
//   digit_valid  digit k holds a recent legal capture
//   digit_err    last stable pattern on digit k was not a legal hex glyph
//   update       one-cycle pulse on any capture (legal or illegal)
//   frame_done   one-cycle pulse once every digit has been captured
//   anode_err    sticky flag: two or more anodes were active at once

module seven_seg_scan_dec #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    update,
  output logic                    frame_done,
  output logic                    anode_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ACT_W = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HELD
  } state_t;

  // Returns {legal, value}; an unrecognised pattern yields legal = 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0010000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Sample stage. Anodes are kept active-high internally so that the reset
  // value (all zero) means "no digit driven" and cannot look like a clash.
  logic [6:0]            seg_s_q, seg_s_d;
  logic [NUM_DIGITS-1:0] an_s_q, an_s_d;
  logic [6:0]            prev_seg_q, prev_seg_d;
  logic [NUM_DIGITS-1:0] prev_an_q, prev_an_d;

  // Observation FSM and stability counter.
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Per-digit result state.
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [AGE_W-1:0]        age_q [NUM_DIGITS];
  logic [AGE_W-1:0]        age_d [NUM_DIGITS];

  // Event outputs and frame tracking.
  logic                  update_q, update_d;
  logic                  frame_done_q, frame_done_d;
  logic                  anode_err_q, anode_err_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;

  // Helpers derived from the current sample.
  logic [ACT_W-1:0]      active_cnt;
  logic                  one_hot;
  logic                  multi;
  logic                  same;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  capture;
  logic [4:0]            glyph;
  logic [NUM_DIGITS-1:0] seen_next;

  // Sample the pins once; the previous sample is kept so stability can be
  // judged by comparing consecutive samples rather than raw pins.
  always_comb begin
    seg_s_d    = seg_n;
    an_s_d     = ~an_n;
    prev_seg_d = seg_s_q;
    prev_an_d  = an_s_q;
  end

  // Classify the sampled anode pattern and compare it to the previous one.
  always_comb begin
    active_cnt = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      active_cnt = active_cnt + ACT_W'(an_s_q[k]);
    end
    one_hot = (active_cnt == ACT_W'(1));
    multi   = (active_cnt > ACT_W'(1));
    same    = (an_s_q == prev_an_q) && (seg_s_q == prev_seg_q);
    cnt_inc = cnt_q + CNT_W'(1);
  end

  // Next-state logic. The counter holds how many identical samples have been
  // seen, including the current one, so a capture fires on the sample that
  // completes the run and the result lands one clock later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!one_hot) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TRACK;
          cnt_d   = CNT_W'(1);
        end
        ST_TRACK: begin
          if (same) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
              capture = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!same) begin
            state_d = ST_TRACK;
            cnt_d   = CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Per-digit capture and ageing. The capturing digit is the single active
  // anode of the current sample. An illegal glyph keeps the last good value
  // but marks the digit as errored and not valid.
  always_comb begin
    glyph    = decode_glyph(seg_s_q);
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (age_q[k] < AGE_W'(TIMEOUT_CYCLES)) begin
        age_d[k] = age_q[k] + AGE_W'(1);
      end else begin
        age_d[k] = age_q[k];
      end
      if (capture && an_s_q[k]) begin
        age_d[k] = '0;
        if (glyph[4]) begin
          digits_d[4*k +: 4] = glyph[3:0];
          valid_d[k]         = 1'b1;
          err_d[k]           = 1'b0;
        end else begin
          valid_d[k] = 1'b0;
          err_d[k]   = 1'b1;
        end
      end else if (age_d[k] == AGE_W'(TIMEOUT_CYCLES)) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // Event pulses and frame bookkeeping. The capture that completes the mask
  // is folded in before the mask is cleared, so it is never lost.
  always_comb begin
    update_d     = capture;
    anode_err_d  = anode_err_q | multi;
    seen_next    = seen_q | (capture ? an_s_q : '0);
    frame_done_d = 1'b0;
    seen_d       = seen_next;
    if (&seen_next) begin
      frame_done_d = 1'b1;
      seen_d       = '0;
    end
  end

  // State registers; reset overrides any capture pending in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s_q      <= '0;
      an_s_q       <= '0;
      prev_seg_q   <= '0;
      prev_an_q    <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      update_q     <= 1'b0;
      frame_done_q <= 1'b0;
      anode_err_q  <= 1'b0;
      seen_q       <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        age_q[k] <= '0;
      end
    end else begin
      seg_s_q      <= seg_s_d;
      an_s_q       <= an_s_d;
      prev_seg_q   <= prev_seg_d;
      prev_an_q    <= prev_an_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      update_q     <= update_d;
      frame_done_q <= frame_done_d;
      anode_err_q  <= anode_err_d;
      seen_q       <= seen_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        age_q[k] <= age_d[k];
      end
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign update      = update_q;
  assign frame_done  = frame_done_q;
  assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seven_seg_scan_dec.sv
// tb_seven_seg_scan_dec
//
// Directed bench for seven_seg_scan_dec. The stimulus process pushes the
// expected result of every capture into a queue; a monitor pops and compares
// whenever the decoder pulses update.

module tb_seven_seg_scan_dec;

  localparam int ND  = 4;
  localparam int SC  = 8;
  localparam int TO  = 300;
  localparam int LAT = SC + 1;

  logic          clk;
  logic          rst;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [15:0]   digits;
  logic [ND-1:0] digit_valid;
  logic [ND-1:0] digit_err;
  logic          update;
  logic          frame_done;
  logic          anode_err;

  seven_seg_scan_dec #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .digits     (digits),
    .digit_valid(digit_valid),
    .digit_err  (digit_err),
    .update     (update),
    .frame_done (frame_done),
    .anode_err  (anode_err)
  );

  typedef struct packed {
    logic [31:0]   cyc;
    logic [15:0]   digits;
    logic [ND-1:0] valid;
    logic [ND-1:0] err;
    logic          frame;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;

  logic [15:0]   m_digits = '0;
  logic [ND-1:0] m_valid = '0;
  logic [ND-1:0] m_err = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Record what the next capture must look like; update appears LAT clocks
  // after the pins first show the pattern.
  task automatic expectCapture(input int k, input logic legal,
                               input logic [3:0] val, input logic frame);
    exp_t e;
    if (legal) begin
      m_digits[4*k +: 4] = val;
      m_valid[k]         = 1'b1;
      m_err[k]           = 1'b0;
    end else begin
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b1;
    end
    e.cyc    = 32'(cyc + LAT);
    e.digits = m_digits;
    e.valid  = m_valid;
    e.err    = m_err;
    e.frame  = frame;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [ND-1:0] an, input logic [6:0] seg,
                               input int hold);
    an_n  = an;
    seg_n = seg;
    repeat (hold) @(negedge clk);
  endtask

  task automatic idle(input int n);
    applyStimulus(4'b1111, 7'b1111111, n);
  endtask

  // Monitor: compares every update pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (update) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_update: got update=1 at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("update_cycle", 32'(cyc), mon_e.cyc);
          checkOutput("digits", 32'(digits), 32'(mon_e.digits));
          checkOutput("digit_valid", 32'(digit_valid), 32'(mon_e.valid));
          checkOutput("digit_err", 32'(digit_err), 32'(mon_e.err));
          checkOutput("frame_done", 32'(frame_done), 32'(mon_e.frame));
        end
      end else if (frame_done) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL frame_without_update: got frame_done=1 at cycle %0d, expected 0", cyc);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no finish after 20000 cycles, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cap_cyc;
    int fall_cyc;
    rst   = 1'b1;
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    repeat (3) @(negedge clk);
    checkOutput("reset_digits", 32'(digits), 32'h0);
    checkOutput("reset_valid", 32'(digit_valid), 32'h0);
    checkOutput("reset_err", 32'(digit_err), 32'h0);
    checkOutput("reset_update", 32'(update), 32'h0);
    checkOutput("reset_anode_err", 32'(anode_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single digit, minimum stable run");
    expectCapture(0, 1'b1, 4'h2, 1'b0);
    applyStimulus(4'b1110, 7'b0100100, SC);
    idle(5);

    $display("[TB] four digit scan 1 A d F");
    expectCapture(0, 1'b1, 4'h1, 1'b0);
    applyStimulus(4'b1110, 7'b1111001, 20);
    expectCapture(1, 1'b1, 4'hA, 1'b0);
    applyStimulus(4'b1101, 7'b0001000, 20);
    expectCapture(2, 1'b1, 4'hD, 1'b0);
    applyStimulus(4'b1011, 7'b0100001, 20);
    expectCapture(3, 1'b1, 4'hF, 1'b1);
    applyStimulus(4'b0111, 7'b0001110, 20);
    idle(3);
    checkOutput("scan_digits", 32'(digits), 32'hFDA1);
    checkOutput("scan_valid", 32'(digit_valid), 32'hF);

    $display("[TB] digit 1 toggling every 5 cycles");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1101, (i % 2 == 0) ? 7'b0100100 : 7'b0000000, 5);
    end
    idle(3);
    checkOutput("toggle_valid1", 32'(digit_valid[1]), 32'h1);
    checkOutput("toggle_digits", 32'(digits), 32'hFDA1);

    $display("[TB] illegal glyph on digit 2");
    expectCapture(2, 1'b0, 4'h0, 1'b0);
    applyStimulus(4'b1011, 7'b1111111, 10);
    idle(3);
    checkOutput("illegal_err", 32'(digit_err), 32'h4);
    checkOutput("illegal_digits", 32'(digits), 32'hFDA1);

    $display("[TB] two anodes at once");
    checkOutput("anode_err_before", 32'(anode_err), 32'h0);
    applyStimulus(4'b1110, 7'b1000000, 5);
    applyStimulus(4'b1100, 7'b1000000, 1);
    applyStimulus(4'b1110, 7'b1000000, 5);
    idle(3);
    checkOutput("anode_err_set", 32'(anode_err), 32'h1);
    idle(5);
    checkOutput("anode_err_sticky", 32'(anode_err), 32'h1);
    checkOutput("anode_digits", 32'(digits), 32'hFDA1);

    $display("[TB] valid timeout on digit 0");
    cap_cyc = cyc + LAT;
    expectCapture(0, 1'b1, 4'h8, 1'b0);
    applyStimulus(4'b1110, 7'b0000000, 10);
    an_n     = 4'b1111;
    seg_n    = 7'b1111111;
    fall_cyc = -1;
    for (int i = 0; i < TO + 60; i++) begin
      @(negedge clk);
      if (!digit_valid[0]) begin
        fall_cyc = cyc;
        break;
      end
    end
    checkOutput("timeout_fall_cycle", 32'(fall_cyc), 32'(cap_cyc + TO));
    checkOutput("timeout_digits_hold", 32'(digits[3:0]), 32'h8);

    $display("[TB] reset on the capture cycle");
    applyStimulus(4'b0111, 7'b0110000, SC);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_digits", 32'(digits), 32'h0);
    checkOutput("rst_valid", 32'(digit_valid), 32'h0);
    checkOutput("rst_err", 32'(digit_err), 32'h0);
    checkOutput("rst_update", 32'(update), 32'h0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    checkOutput("rst_anode_err", 32'(anode_err), 32'h0);
    rst   = 1'b0;
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    idle(12);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
